// File: rtl/wb_copy_engine.sv
// ---------------------------------------------------------------------------
// wb_copy_engine
//
// Wishbone pipelined master that copies a block of 32-bit words from one
// word address to another, one word at a time (read, then write). It sits
// directly in front of one port of the dual-port big_ram.
//
// Optional feature macro: WB_COPY_TIMEOUT_EN
//   Defined     : an ack timeout aborts the copy and pulses err_o.
//   Not defined : the engine waits for ack indefinitely; err_o is tied 0.
//
// Handshake: a request is accepted on a rising edge where wb_stb_o is high
// and wb_stall_i is low; while stalled, stb/we/addr/data are held stable.
// Each accepted request is completed by exactly one wb_ack_i, which arrives
// at least one cycle after acceptance. Acks outside the wait states are
// ignored.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle copy request (sampled in IDLE only)
//   src_addr_i, dst_addr_i  first source / destination word address
//   len_i                   word count 0..2^AW
//   busy_o                  high in every state except IDLE
//   done_o                  one-cycle completion pulse
//   err_o                   one-cycle timeout-abort pulse
//   wb_*                    Wishbone master signals towards big_ram
//   dbg_state_o             current FSM state, for debug / checkers
// ---------------------------------------------------------------------------
module wb_copy_engine #(
    parameter int AW             = 11,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] src_addr_i,
    input  logic [AW-1:0] dst_addr_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    output logic [3:0]    wb_sel_o,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i,
    input  logic [DW-1:0] wb_data_i,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_len;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_wdata;

    logic          w_accept;
    logic          w_waiting;
    logic          w_abort;
    logic [AW:0]   w_count_inc;

    assign w_accept    = wb_stb_o && !wb_stall_i;
    assign w_waiting   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_count_inc = r_count + (AW+1)'(1);
    assign dbg_state_o = r_state;
    assign wb_sel_o    = 4'hF;

`ifdef WB_COPY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // r_tmo counts wait cycles since the last acceptance; the copy aborts
    // on the edge that would be wait cycle TIMEOUT_CYCLES without an ack.
    assign w_abort = w_waiting && !wb_ack_i &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (w_accept) begin
                r_tmo <= '0;
            end else if (w_waiting) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_abort      = 1'b0;
    assign err_o        = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (len_i != '0) ? S_RD_REQ : S_FINISH;
                end
            end
            S_RD_REQ:  if (w_accept) w_next = S_RD_WAIT;
            S_RD_WAIT: if (wb_ack_i) w_next = S_WR_REQ;
            S_WR_REQ:  if (w_accept) w_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (wb_ack_i) begin
                    w_next = (w_count_inc == r_len) ? S_FINISH : S_RD_REQ;
                end
            end
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // Bus and status outputs decoded from the registered state
    always_comb begin
        busy_o    = (r_state != S_IDLE);
        done_o    = (r_state == S_FINISH);
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_data_o = '0;
        case (r_state)
            S_RD_REQ: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_addr_o = r_src + r_count[AW-1:0];  // wraps modulo 2^AW
            end
            S_RD_WAIT: begin
                wb_cyc_o  = 1'b1;
            end
            S_WR_REQ: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_we_o   = 1'b1;
                wb_addr_o = r_dst + r_count[AW-1:0];
                wb_data_o = r_wdata;
            end
            S_WR_WAIT: begin
                wb_cyc_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        r_src   <= src_addr_i;
                        r_dst   <= dst_addr_i;
                        r_len   <= len_i;
                        r_count <= '0;
                    end
                end
                S_RD_WAIT: if (wb_ack_i) r_wdata <= wb_data_i;
                S_WR_WAIT: if (wb_ack_i) r_count <= w_count_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_wb_copy_engine
//
// Drives wb_copy_engine against a behavioural Wishbone memory slave with
// configurable stall length and ack delay. Expected memory contents come
// from a plain array copy; expected latency comes from a per-word cycle
// formula (request cycles + wait cycles, twice per word, plus one).
// ---------------------------------------------------------------------------
module tb_wb_copy_engine;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MEM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] src_addr_i = '0;
    logic [AW-1:0] dst_addr_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o, err_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [3:0]    wb_sel_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_stall_i = 1'b0;
    logic [DW-1:0] wb_data_i = '0;
    logic [2:0]    dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_copy_engine #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_data_i(wb_data_i),
        .dbg_state_o(dbg_state_o)
    );

    // clock
    always #5 clk = ~clk;

    // memory seen by the slave, and the reference image
    logic [DW-1:0] mem     [MEM_WORDS];
    logic [DW-1:0] ref_mem [MEM_WORDS];

    // slave configuration and state
    int            stall_cfg = 0;
    int            ack_delay = 1;
    bit            no_ack = 0;
    bit            acc_pend = 0;
    int            stall_left = 0;
    int            ack_wait = 0;
    bit            stalled_prev = 0;
    logic [AW-1:0] p_addr, h_addr;
    logic          p_we, h_we;
    logic [DW-1:0] p_data, h_data;
    int            stab_viol = 0;
    int            wr_acc = 0;

    // Slave: drives stall/ack at negedges so the DUT sees them settled.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        if (acc_pend) begin
            wb_stall_i   = 1'b0;
            stalled_prev = 0;
            if (ack_wait > 1) begin
                ack_wait--;
            end else begin
                acc_pend = 0;
                if (!no_ack) begin
                    if (p_we) mem[p_addr] = p_data;
                    else      wb_data_i   = mem[p_addr];
                    wb_ack_i = 1'b1;
                end
            end
        end else if (wb_stb_o) begin
            if (stalled_prev && (wb_addr_o !== h_addr || wb_we_o !== h_we ||
                                 wb_data_o !== h_data))
                stab_viol++;
            if (stall_left > 0) begin
                wb_stall_i   = 1'b1;
                stall_left--;
                stalled_prev = 1;
                h_addr = wb_addr_o; h_we = wb_we_o; h_data = wb_data_o;
            end else begin
                wb_stall_i   = 1'b0;
                stalled_prev = 0;
                acc_pend     = 1;
                ack_wait     = ack_delay;
                p_addr = wb_addr_o; p_we = wb_we_o; p_data = wb_data_o;
                stall_left   = stall_cfg;
                if (wb_we_o) wr_acc++;
            end
        end else begin
            wb_stall_i   = 1'b0;
            stalled_prev = 0;
        end
    end

    task automatic config_slave(input int stall, input int ackd);
        stall_cfg  = stall;
        stall_left = stall;
        ack_delay  = ackd;
    endtask

    function automatic void ref_copy(input int s, input int d, input int n);
        for (int i = 0; i < n; i++)
            ref_mem[(d + i) % MEM_WORDS] = ref_mem[(s + i) % MEM_WORDS];
    endfunction

    function automatic int mem_diffs();
        int b = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== ref_mem[i]) b++;
        return b;
    endfunction

    // Starts a copy; c counts cycles after the start edge (c=1 is the
    // cycle right after it). Returns first done cycle and busy-drop cycle.
    task automatic run_copy(input int s, input int d, input int n, input int budget,
                            output int done_at, output int done_pulses,
                            output int busy_drop_at, output bit cyc_seen);
        @(negedge clk);
        src_addr_i = AW'(s); dst_addr_i = AW'(d); len_i = (AW+1)'(n);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        done_at = -1; done_pulses = 0; busy_drop_at = -1; cyc_seen = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk);
            if (wb_cyc_o) cyc_seen = 1;
            if (done_o) begin
                done_pulses++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && !busy_o) begin
                busy_drop_at = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_checks++; if (done_o !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_checks++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
        n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000)
            begin n_fail++; $display("FAIL reset_bus got=%b exp=000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        n_checks++; if (wb_addr_o !== '0)   begin n_fail++; $display("FAIL reset_addr got=%h exp=0", wb_addr_o); end
        n_checks++; if (wb_data_o !== '0)   begin n_fail++; $display("FAIL reset_data got=%h exp=0", wb_data_o); end
        n_checks++; if (wb_sel_o !== 4'hF)  begin n_fail++; $display("FAIL reset_sel got=%h exp=f", wb_sel_o); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int da, dp, bd; bit cs;
        mem[4] = 32'hDEADBEEF; mem[5] = 32'hBEEFCAFE; mem[6] = 32'h12345678;
        ref_mem[4] = mem[4]; ref_mem[5] = mem[5]; ref_mem[6] = mem[6];
        config_slave(0, 1);
        ref_copy(11'h004, 11'h404, 3);
        run_copy(11'h004, 11'h404, 3, 60, da, dp, bd, cs);
        n_checks++; if (da !== 13) begin n_fail++; $display("FAIL basic_done_latency got=%0d exp=13", da); end
        n_checks++; if (dp !== 1)  begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", dp); end
        n_checks++; if (bd !== 14) begin n_fail++; $display("FAIL basic_busy_drop got=%0d exp=14", bd); end
        n_checks++; if (mem[11'h405] !== 32'hBEEFCAFE)
            begin n_fail++; $display("FAIL basic_word1 got=%h exp=beefcafe", mem[11'h405]); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL basic_mem got=%0d diffs exp=0", mem_diffs()); end
    endtask

    task automatic test_len_zero();
        int da, dp, bd; bit cs;
        run_copy(11'h010, 11'h020, 0, 20, da, dp, bd, cs);
        n_checks++; if (da !== 1)  begin n_fail++; $display("FAIL len0_done got=%0d exp=1", da); end
        n_checks++; if (cs !== 0)  begin n_fail++; $display("FAIL len0_cyc got=%0d exp=0", cs); end
        n_checks++; if (dp !== 1)  begin n_fail++; $display("FAIL len0_pulses got=%0d exp=1", dp); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL len0_mem got=%0d diffs exp=0", mem_diffs()); end
    endtask

    task automatic test_wrap();
        int da, dp, bd; bit cs;
        config_slave(0, 1);
        ref_copy(11'h7FE, 11'h100, 4);
        run_copy(11'h7FE, 11'h100, 4, 60, da, dp, bd, cs);
        n_checks++; if (da !== 17) begin n_fail++; $display("FAIL wrap_latency got=%0d exp=17", da); end
        n_checks++; if (mem[11'h102] !== mem[11'h000])
            begin n_fail++; $display("FAIL wrap_word2 got=%h exp=%h", mem[11'h102], mem[11'h000]); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL wrap_mem got=%0d diffs exp=0", mem_diffs()); end
    endtask

    task automatic test_stall();
        int da, dp, bd; bit cs;
        config_slave(3, 1);
        stab_viol = 0;
        ref_copy(11'h200, 11'h300, 4);
        run_copy(11'h200, 11'h300, 4, 100, da, dp, bd, cs);
        n_checks++; if (da !== 41) begin n_fail++; $display("FAIL stall_latency got=%0d exp=41", da); end
        n_checks++; if (stab_viol !== 0)
            begin n_fail++; $display("FAIL stall_stable got=%0d violations exp=0", stab_viol); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL stall_mem got=%0d diffs exp=0", mem_diffs()); end
        config_slave(0, 1);
    endtask

    task automatic test_random();
        int da, dp, bd, s, d, n, st, ak, exp_lat; bit cs;
        for (int it = 0; it < 6; it++) begin
            s  = $urandom_range(0, MEM_WORDS - 1);
            d  = $urandom_range(0, MEM_WORDS - 1);
            n  = $urandom_range(1, 8);
            st = $urandom_range(0, 2);
            ak = $urandom_range(1, 3);
            config_slave(st, ak);
            exp_lat = n * (2 * (1 + st) + 2 * ak) + 1;
            ref_copy(s, d, n);
            run_copy(s, d, n, 400, da, dp, bd, cs);
            n_checks++; if (da !== exp_lat)
                begin n_fail++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, da, exp_lat); end
            n_checks++; if (mem_diffs() !== 0)
                begin n_fail++; $display("FAIL rand_mem it=%0d got=%0d diffs exp=0", it, mem_diffs()); end
        end
        config_slave(0, 1);
    endtask

    // A start pulse while busy must be dropped, not queued.
    task automatic test_back_to_back();
        int da, dp, bd; bit cs;
        int done_cnt = 0;
        config_slave(0, 1);
        ref_copy(11'h050, 11'h060, 3);
        @(negedge clk);
        src_addr_i = 11'h050; dst_addr_i = 11'h060; len_i = 12'd3; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 4) begin
                src_addr_i = 11'h070; dst_addr_i = 11'h080; len_i = 12'd2; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) done_cnt++;
        end
        start_i = 1'b0;
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL b2b_mem got=%0d diffs exp=0", mem_diffs()); end
        ref_copy(11'h070, 11'h080, 2);
        run_copy(11'h070, 11'h080, 2, 40, da, dp, bd, cs);
        n_checks++; if (da !== 9) begin n_fail++; $display("FAIL b2b_next_latency got=%0d exp=9", da); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL b2b_next_mem got=%0d diffs exp=0", mem_diffs()); end
    endtask

    task automatic test_mid_reset();
        int da, dp, bd; bit cs;
        bit found = 0;
        int late_done = 0, late_busy = 0;
        config_slave(0, 4);
        wr_acc = 0;
        @(negedge clk);
        src_addr_i = 11'h400; dst_addr_i = 11'h500; len_i = 12'd5; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (wr_acc == 2) begin found = 1; break; end
            @(negedge clk);
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL midrst_reach got=%0d exp=1", found); end
        @(negedge clk);          // second write accepted, now waiting for ack
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        n_checks++; if ({wb_cyc_o, busy_o, done_o} !== 3'b000)
            begin n_fail++; $display("FAIL midrst_outputs got=%b exp=000", {wb_cyc_o, busy_o, done_o}); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_o) late_done++;
            if (busy_o) late_busy++;
        end
        n_checks++; if (late_done + late_busy !== 0)
            begin n_fail++; $display("FAIL midrst_ignored got=%0d exp=0", late_done + late_busy); end
        ref_copy(11'h400, 11'h500, 2);   // words 0 and 1 completed at the slave
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL midrst_mem got=%0d diffs exp=0", mem_diffs()); end
        config_slave(0, 1);
        ref_copy(11'h400, 11'h500, 5);
        run_copy(11'h400, 11'h500, 5, 60, da, dp, bd, cs);
        n_checks++; if (da !== 21) begin n_fail++; $display("FAIL midrst_restart got=%0d exp=21", da); end
        n_checks++; if (mem_diffs() !== 0)
            begin n_fail++; $display("FAIL midrst_restart_mem got=%0d diffs exp=0", mem_diffs()); end
    endtask

`ifdef WB_COPY_TIMEOUT_EN
    // Acceptance on edge 1; 16 cycles later the abort edge, err seen at c=18.
    task automatic test_timeout();
        int err_at = -1, err_pulses = 0, done_cnt = 0;
        logic cyc_at_err = 1'b1;
        config_slave(0, 1);
        no_ack = 1;
        @(negedge clk);
        src_addr_i = 11'h600; dst_addr_i = 11'h610; len_i = 12'd2; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (err_o) begin
                err_pulses++;
                if (err_at < 0) begin err_at = c; cyc_at_err = wb_cyc_o; end
            end
            if (done_o) done_cnt++;
        end
        no_ack = 0;
        n_checks++; if (err_at !== 18) begin n_fail++; $display("FAIL tmo_err_at got=%0d exp=18", err_at); end
        n_checks++; if (err_pulses !== 1) begin n_fail++; $display("FAIL tmo_err_pulses got=%0d exp=1", err_pulses); end
        n_checks++; if (cyc_at_err !== 1'b0) begin n_fail++; $display("FAIL tmo_cyc got=%b exp=0", cyc_at_err); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL tmo_done got=%0d exp=0", done_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_stall();
        test_random();
        test_back_to_back();
        test_mid_reset();
`ifdef WB_COPY_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_copy_engine.md
Name: wb_copy_engine

Overview:
- Wishbone pipelined master that copies a block of 32-bit words from one word address to another.
- Sits directly upstream of one port (A or B) of the dual-port big_ram; drives that port's cyc/stb/we/addr/data/sel and consumes its ack/stall/data.
- Controlled by a start pulse from a host or sequencer; one transfer in flight at a time.

Parameters:
- AW, 11, word address width (matches big_ram port)
- DW, 32, data width
- TIMEOUT_CYCLES, 16, ack timeout limit; used only when WB_COPY_TIMEOUT_EN is defined

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle copy request; sampled in IDLE only
- src_addr_i  in  AW  first source word address
- dst_addr_i  in  AW  first destination word address
- len_i  in  AW+1  word count, 0..2048
- busy_o  out  1  copy in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle timeout-abort pulse; tied 0 without WB_COPY_TIMEOUT_EN
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_addr_o  out  AW  word address
- wb_data_o  out  DW  write data
- wb_sel_o  out  4  byte select; constant 4'hF
- wb_ack_i  in  1  slave acknowledge
- wb_stall_i  in  1  slave stall
- wb_data_i  in  DW  slave read data

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: busy_o, done_o, err_o, wb_cyc_o, wb_stb_o and wb_we_o are 0. wb_addr_o and wb_data_o are 0. State is IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE:
  - On start_i with len_i != 0: latch src, dst and len; clear the word counter; go to RD_REQ.
  - On start_i with len_i == 0: go to FINISH with no bus activity.
- RD_REQ: drive cyc=1, stb=1, we=0, addr = src + count.
  - The request is accepted on an edge where stb & !stall_i.
  - On acceptance: drop stb and go to RD_WAIT.
  - While stalled: hold stb, addr and we stable.
- RD_WAIT: cyc=1, stb=0. On ack_i, capture wb_data_i into the write-data register and go to WR_REQ.
- WR_REQ: drive stb=1, we=1, addr = dst + count, data = captured word. Acceptance works as in RD_REQ; on acceptance go to WR_WAIT.
- WR_WAIT:
  - On ack_i: increment count.
  - If count+1 == len, go to FINISH.
  - Otherwise go to RD_REQ.
- FINISH: done_o=1 for exactly one cycle; cyc=0; return to IDLE.
- wb_cyc_o stays high continuously from the first RD_REQ through the final WR_WAIT ack. It drops in FINISH.
- Acks: ack_i in any state other than RD_WAIT or WR_WAIT is ignored. Slave acks arrive at least 1 cycle after acceptance.
- Address arithmetic: modulo 2^AW. For example, src 0x7FF followed by the next word gives 0x000. Overlapping source and destination ranges are copied in ascending order with no hazard protection.
- Timing: with no stall and ack the cycle after acceptance, each word takes 4 cycles. done_o is asserted the cycle after the last write ack. A 3-word copy therefore gives start edge→done = 13 cycles.
- busy_o = 1 in every state except IDLE; it is 1 in FINISH.
- start_i while busy_o is ignored and does not queue.
- rst_i mid-copy: at the next edge all outputs return to reset values and cyc drops. Any partially written block is left as is.

Optional Feature:
- Macro: WB_COPY_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RD_WAIT and WR_WAIT.
  - If ack_i is not seen within TIMEOUT_CYCLES cycles of acceptance, the copy aborts: cyc/stb drop, err_o pulses for one cycle, done_o is not asserted, return to IDLE.
  - The counter clears on every acceptance.
- Not defined:
  - No counter logic; the block waits indefinitely for ack.
  - err_o is constant 0.

Test Plan:
- Copy from big_ram: preload 0x004..0x006 = DEADBEEF, BEEFCAFE, 12345678; start src=0x004 dst=0x404 len=3 -> reads of 0x404..0x406 return the same three words; done_o pulses once, 13 cycles after the start edge; busy_o drops the following cycle.
- len=0 -> done_o the cycle after start; wb_cyc_o never asserts; memory is unchanged.
- Wrap: src=0x7FE len=4, dst=0x100 -> words from 0x7FE, 0x7FF, 0x000, 0x001 land at 0x100..0x103.
- Stall: a stub slave holds stall_i=1 for 3 cycles on every request -> stb, addr, we and data stay stable while stalled; each word takes 10 cycles; data copies correctly.
- Mid-copy reset: assert rst_i in WR_WAIT of word 2 of 5 -> next edge gives cyc=0, busy=0, done=0; later acks are ignored; a new start copies correctly.
- With WB_COPY_TIMEOUT_EN and TIMEOUT_CYCLES=16, a stub slave that never acks -> err_o pulses 16 cycles after the first acceptance; cyc drops; done_o stays 0.
